// File: rtl/hpu_pkg.sv
// Shared definitions for the HPU phase sequencer: state encoding,
// default widths and bit positions of the status word.
package hpu_pkg;

  localparam int ITEM_W_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT = 20;
  localparam int CYC_W_DEFAULT  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_READY = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  // Status word layout: {run_cycles, err, done, busy, mem_valid, run, gen}
  localparam int STAT_GEN_BIT        = 0;
  localparam int STAT_RUN_BIT        = 1;
  localparam int STAT_MEM_VALID_BIT  = 2;
  localparam int STAT_BUSY_BIT       = 3;
  localparam int STAT_DONE_BIT       = 4;
  localparam int STAT_ERR_BIT        = 5;
  localparam int STAT_RUN_CYCLES_LSB = 6;

endpackage

// File: rtl/hpu_sequencer.sv
// Phase controller for the HPU datapath: sequences item-memory generation
// and stream processing, latching configuration at phase entry.
module hpu_sequencer
  import hpu_pkg::*;
#(
  parameter int ITEM_W = ITEM_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int CYC_W  = CYC_W_DEFAULT
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESETN,
  input  logic              cmd_gen,
  input  logic              cmd_run,
  input  logic              cmd_abort,
  input  logic [ITEM_W-1:0] cfg_item_num,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [ADDR_W-1:0] cfg_addr_j,
  input  logic              out_beat,
  input  logic              out_last,
  output logic              gen,
  output logic              run,
  output logic [ITEM_W-1:0] item_a,
  output logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_j,
  output logic              mem_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CYC_W-1:0]  run_cycles
);

  state_e            state_q, state_d;
  logic [ITEM_W-1:0] item_num_q, item_num_d;
  logic [ITEM_W-1:0] item_a_q, item_a_d;
  logic [ADDR_W-1:0] addr_i_q, addr_i_d;
  logic [ADDR_W-1:0] addr_j_q, addr_j_d;
  logic              mem_valid_q, mem_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CYC_W-1:0]  run_cycles_q, run_cycles_d;

  logic cmd_both, cmd_any, gen_last, run_end;

  always_comb begin
    state_d      = state_q;
    item_num_d   = item_num_q;
    item_a_d     = item_a_q;
    addr_i_d     = addr_i_q;
    addr_j_d     = addr_j_q;
    mem_valid_d  = mem_valid_q;
    done_d       = done_q;
    err_d        = err_q;
    run_cycles_d = run_cycles_q;

    cmd_both = cmd_gen & cmd_run;
    cmd_any  = cmd_gen | cmd_run;
    gen_last = (item_a_q == item_num_q - ITEM_W'(1));
    run_end  = out_beat & out_last;

    if (cmd_abort) begin
      err_d = 1'b0;
      case (state_q)
        ST_GEN: begin
          state_d     = ST_IDLE;
          mem_valid_d = 1'b0;
        end
        ST_RUN: begin
          state_d = ST_READY;
          done_d  = 1'b0;
        end
        default: ;
      endcase
    end else begin
      case (state_q)
        ST_IDLE, ST_READY: begin
          if (cmd_both) begin
            err_d = 1'b1;
          end else if (cmd_gen) begin
            // A zero-length generation completes without any gen cycle.
            item_num_d  = cfg_item_num;
            item_a_d    = '0;
            done_d      = 1'b0;
            mem_valid_d = (cfg_item_num == '0);
            state_d     = (cfg_item_num == '0) ? ST_READY : ST_GEN;
          end else if (cmd_run) begin
            if (state_q == ST_READY) begin
              addr_i_d     = cfg_addr_i;
              addr_j_d     = cfg_addr_j;
              run_cycles_d = '0;
              done_d       = 1'b0;
              state_d      = ST_RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_GEN: begin
          if (cmd_any) err_d = 1'b1;
          if (gen_last) begin
            state_d     = ST_READY;
            mem_valid_d = 1'b1;
          end else begin
            item_a_d = item_a_q + ITEM_W'(1);
          end
        end
        ST_RUN: begin
          if (cmd_any) err_d = 1'b1;
          if (run_cycles_q != '1) run_cycles_d = run_cycles_q + CYC_W'(1);
          if (run_end) begin
            state_d = ST_READY;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q      <= ST_IDLE;
      item_num_q   <= '0;
      item_a_q     <= '0;
      addr_i_q     <= '0;
      addr_j_q     <= '0;
      mem_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      item_num_q   <= item_num_d;
      item_a_q     <= item_a_d;
      addr_i_q     <= addr_i_d;
      addr_j_q     <= addr_j_d;
      mem_valid_q  <= mem_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  // Enables decode straight from the state flop, so they stay registered.
  assign gen        = (state_q == ST_GEN);
  assign run        = (state_q == ST_RUN);
  assign busy       = (state_q == ST_GEN) || (state_q == ST_RUN);
  assign item_a     = item_a_q;
  assign addr_i     = addr_i_q;
  assign addr_j     = addr_j_q;
  assign mem_valid  = mem_valid_q;
  assign done       = done_q;
  assign err        = err_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_hpu_sequencer.sv
// Scoreboard bench for hpu_sequencer: a phase-level reference model predicts
// the registered outputs after every clock edge; a monitor compares them.
module tb_hpu_sequencer;

  localparam int ITEM_W = 16;
  localparam int ADDR_W = 20;
  localparam int CYC_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_gen = 1'b0, cmd_run = 1'b0, cmd_abort = 1'b0;
  logic [ITEM_W-1:0] cfg_item_num = '0;
  logic [ADDR_W-1:0] cfg_addr_i = '0, cfg_addr_j = '0;
  logic              out_beat = 1'b0, out_last = 1'b0;
  logic              gen, run, mem_valid, busy, done, err;
  logic [ITEM_W-1:0] item_a;
  logic [ADDR_W-1:0] addr_i, addr_j;
  logic [CYC_W-1:0]  run_cycles;

  always #5 clk = ~clk;

  hpu_sequencer #(.ITEM_W(ITEM_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W)) dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESETN (rst_n),
    .cmd_gen      (cmd_gen),
    .cmd_run      (cmd_run),
    .cmd_abort    (cmd_abort),
    .cfg_item_num (cfg_item_num),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_addr_j   (cfg_addr_j),
    .out_beat     (out_beat),
    .out_last     (out_last),
    .gen          (gen),
    .run          (run),
    .item_a       (item_a),
    .addr_i       (addr_i),
    .addr_j       (addr_j),
    .mem_valid    (mem_valid),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .run_cycles   (run_cycles)
  );

  typedef struct {
    bit              gen, run, mem_valid, busy, done, err;
    int unsigned     item_a, addr_i, addr_j;
    longint unsigned run_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;

  // Reference model: a generation is "gen_left cycles still to go",
  // a run is a flag; memory-valid decides whether a run may start.
  int              gen_left;
  int unsigned     m_item_a, m_ai, m_aj;
  bit              m_run, m_mem, m_done, m_err;
  longint unsigned m_cyc;
  localparam longint unsigned CYC_MAX = (64'd1 << CYC_W) - 1;

  function automatic void modelReset();
    gen_left = 0; m_item_a = 0; m_ai = 0; m_aj = 0;
    m_run = 0; m_mem = 0; m_done = 0; m_err = 0; m_cyc = 0;
  endfunction

  function automatic void modelStep(bit g, bit r, bit a, int unsigned n,
                                    int unsigned ai, int unsigned aj,
                                    bit beat, bit last);
    bit was_busy, illegal;
    was_busy = (gen_left > 0) || m_run;
    if (a) begin
      m_err = 0;
      if (gen_left > 0) begin
        gen_left = 0;
        m_mem = 0;
      end else if (m_run) begin
        m_run = 0;
        m_done = 0;
      end
      return;
    end
    if (was_busy) illegal = g || r;
    else          illegal = (g && r) || (r && !m_mem);
    if (illegal) m_err = 1;
    if (gen_left > 0) begin
      if (gen_left > 1) m_item_a++;
      gen_left--;
      if (gen_left == 0) m_mem = 1;
    end
    if (m_run) begin
      if (m_cyc < CYC_MAX) m_cyc++;
      if (beat && last) begin
        m_run = 0;
        m_done = 1;
      end
    end
    if (!was_busy && !illegal) begin
      if (g) begin
        gen_left = int'(n);
        m_item_a = 0;
        m_mem = (n == 0);
        m_done = 0;
      end else if (r) begin
        m_run = 1; m_cyc = 0; m_done = 0;
        m_ai = ai; m_aj = aj;
      end
    end
  endfunction

  function automatic exp_t modelOut();
    exp_t e;
    e.gen = (gen_left > 0);
    e.run = m_run;
    e.busy = (gen_left > 0) || m_run;
    e.mem_valid = m_mem;
    e.done = m_done;
    e.err = m_err;
    e.item_a = m_item_a;
    e.addr_i = m_ai;
    e.addr_j = m_aj;
    e.run_cycles = m_cyc;
    return e;
  endfunction

  function automatic int unsigned rndAddr();
    return $urandom_range(0, (1 << ADDR_W) - 1);
  endfunction

  task automatic checkOutput(string name, longint unsigned act, longint unsigned expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Called at a negedge; drives one cycle of inputs and advances to the next negedge.
  task automatic applyStimulus(bit g, bit r, bit a, int unsigned n,
                               int unsigned ai, int unsigned aj, bit beat, bit last);
    cmd_gen = g; cmd_run = r; cmd_abort = a;
    cfg_item_num = n[ITEM_W-1:0];
    cfg_addr_i = ai[ADDR_W-1:0];
    cfg_addr_j = aj[ADDR_W-1:0];
    out_beat = beat; out_last = last;
    modelStep(g, r, a, n, ai, aj, beat, last);
    exp_q.push_back(modelOut());
    @(negedge clk);
  endtask

  task automatic idle(int k);
    for (int i = 0; i < k; i++)
      applyStimulus(0, 0, 0, $urandom_range(0, 2000), rndAddr(), rndAddr(), 0, 0);
  endtask

  task automatic checkResetValues(string tag);
    checkOutput({tag, "_gen"}, gen, 0);
    checkOutput({tag, "_run"}, run, 0);
    checkOutput({tag, "_item_a"}, item_a, 0);
    checkOutput({tag, "_addr_i"}, addr_i, 0);
    checkOutput({tag, "_addr_j"}, addr_j, 0);
    checkOutput({tag, "_mem_valid"}, mem_valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_run_cycles"}, run_cycles, 0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must drop at once.
  task automatic resetMidCycle();
    cmd_gen = 0; cmd_run = 0; cmd_abort = 0; out_beat = 0; out_last = 0;
    #2 rst_n = 1'b0;
    #1 checkResetValues("async_rst");
    mon_en = 1'b0;
    exp_q.delete();
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkResetValues("post_rst");
    mon_en = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("gen", gen, e.gen);
        checkOutput("run", run, e.run);
        checkOutput("busy", busy, e.busy);
        checkOutput("mem_valid", mem_valid, e.mem_valid);
        checkOutput("done", done, e.done);
        checkOutput("err", err, e.err);
        checkOutput("item_a", item_a, e.item_a);
        checkOutput("addr_i", addr_i, e.addr_i);
        checkOutput("addr_j", addr_j, e.addr_j);
        checkOutput("run_cycles", run_cycles, e.run_cycles);
      end
    end
  end

  initial begin : stimulus
    int beats;
    bit beat, last;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkResetValues("reset");
    mon_en = 1'b1;

    $display("[TB] illegal run from IDLE, then abort");
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    idle(1);

    $display("[TB] generate 1000 items");
    applyStimulus(1, 0, 0, 1000, 0, 0, 0, 0);
    idle(1005);

    $display("[TB] run with addr 149/2, ten beats, toggling ready");
    applyStimulus(0, 1, 0, 7, 149, 2, 0, 0);
    beats = 0;
    for (int c = 0; c < 100 && beats < 10; c++) begin
      beat = c[0];
      last = beat && (beats == 9);
      if (!beat && (c % 3 == 0)) last = 1;
      applyStimulus(0, 0, 0, $urandom_range(0, 50), rndAddr(), rndAddr(), beat, last);
      if (beat) beats++;
    end
    idle(3);

    $display("[TB] zero-length and single-item generation");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
    idle(3);

    $display("[TB] abort mid-generation");
    applyStimulus(1, 0, 0, 1000, 0, 0, 0, 0);
    idle(500);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    idle(2);

    $display("[TB] commands while busy, abort mid-run, double command in READY");
    applyStimulus(1, 0, 0, 5, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    idle(6);
    applyStimulus(0, 1, 0, 0, 33, 44, 0, 0);
    idle(4);
    applyStimulus(1, 0, 0, 3, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 1);
    idle(2);
    applyStimulus(1, 1, 0, 4, 7, 8, 0, 0);
    idle(2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2500; i++)
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 99) == 0, $urandom_range(0, 12),
                    rndAddr(), rndAddr(), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0);

    $display("[TB] reset during run");
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 4, 0, 0, 0, 0);
    idle(6);
    applyStimulus(0, 1, 0, 0, 5, 6, 0, 0);
    idle(3);
    resetMidCycle();
    idle(3);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
